// File: rtl/pulse_interval_meter.sv
// rtl/pulse_interval_meter.sv - rising-edge interval meter with interval FIFO and running statistics
// Measures cycles between successive pulse_in rising edges, queues them, and tracks count/min/max/flags.
module pulse_interval_meter #(
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [CNT_W-1:0] interval_data,
  output logic             interval_valid,
  input  logic             interval_ready,
  output logic [15:0]      pulse_count,
  output logic [CNT_W-1:0] min_interval,
  output logic [CNT_W-1:0] max_interval,
  output logic             sat_flag,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [OW-1:0]    FULL_OCC = OW'(DEPTH);
  localparam logic [OW-1:0]    ONE_OCC  = OW'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      pc_q, pc_d;
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
  logic             sat_q, sat_d, ovf_q, ovf_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [CNT_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] mem_d [DEPTH];

  logic edge_det, capture, pop, full, push;
  logic [PW-1:0] rd_next;

  always_comb begin
    edge_det = pulse_in & ~prev_q & ~clear;
    capture  = edge_det & (state_q == MEASURE);
    pop      = (occ_q != '0) & interval_ready;
    full     = (occ_q == FULL_OCC);
    push     = capture & (~full | pop);
    rd_next  = rd_q + 1'b1;

    prev_d  = pulse_in;
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    min_d   = min_q;
    max_d   = max_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    occ_d   = occ_q;
    head_d  = head_q;
    mem_d   = mem_q;

    case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (edge_det)              cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (edge_det && pc_q != 16'hFFFF) pc_d = pc_q + 16'd1;

    // Statistics see every capture, even one the full FIFO drops.
    if (capture) begin
      if (cnt_q < min_q) min_d = cnt_q;
      if (cnt_q > max_q) max_d = cnt_q;
      if (cnt_q == CNT_MAX) sat_d = 1'b1;
      if (full && !pop) ovf_d = 1'b1;
    end

    if (push) begin
      mem_d[wr_q] = cnt_q;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_next;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // head_q mirrors the FIFO head so the output is a plain register.
    if (push && (occ_q == '0 || (pop && occ_q == ONE_OCC))) head_d = cnt_q;
    else if (pop && occ_q > ONE_OCC)                        head_d = mem_q[rd_next];

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      pc_d    = '0;
      min_d   = '1;
      max_d   = '0;
      sat_d   = 1'b0;
      ovf_d   = 1'b0;
      wr_d    = '0;
      rd_d    = '0;
      occ_d   = '0;
      head_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      pc_q    <= '0;
      min_q   <= '1;
      max_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
    end
    mem_q <= mem_d;
  end

  assign interval_data  = head_q;
  assign interval_valid = (occ_q != '0);
  assign pulse_count    = pc_q;
  assign min_interval   = min_q;
  assign max_interval   = max_q;
  assign sat_flag       = sat_q;
  assign overflow       = ovf_q;

endmodule
